pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Consumer of the ID-stage control decoder's PC-select outputs. Owns the program counter, including the kernel bit PC[31] that is fed back to the decoder as PCH. Resolves next-PC priority among EX-stage branch redirect, stall, interrupt, undefined-instruction exception, jumps and sequential fetch. Drives pipeline flushes and the exception return address (EPC) written to $26.

Parameters:
RESET_VEC, 32'h8000_0000, PC loaded on reset
ILLOP_VEC, 32'h8000_0004, undefined-instruction handler entry
XADR_VEC, 32'h8000_0008, interrupt handler entry

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_src  in  3  decoder PC select: 000 seq, 001 j/jal/jalr-imm, 010 jr, 011 branch-in-ID, 100 stall, 101 UI
id_pc_plus4  in  32  PC+4 of the instruction in ID
id_jump_idx  in  26  instr[25:0] of the ID instruction
id_jr_data  in  32  forwarded rs value for jr/jalr
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  branch target from EX
irq  in  1  level-sensitive external interrupt (timer)
pc  out  32  current fetch address (registered)
pch  out  1  pc[31], kernel-mode flag
if_flush  out  1  load bubble into IF/ID this cycle
id_flush  out  1  load bubble into ID/EX this cycle
epc_we  out  1  write epc to $26 via pipeline
epc  out  32  return address; 0 when epc_we=0
irq_ack  out  1  one-cycle pulse: interrupt accepted
exc_cause  out  2  00 none, 01 ILLOP, 10 XADR

Behaviour:
- Reset (synchronous, overrides everything, including mid-redirect): pc=RESET_VEC, state=RUN, irq_pending=0. All combinational outputs are 0 while reset=1.
- irq_pending: set on any cycle with irq=1. Cleared only on acceptance.
- FSM states are RUN and FLUSH.
  - Any redirect (branch, jump, jr, UI, irq) moves to FLUSH for exactly one cycle, then returns to RUN.
  - Stall (pc_src=100) in FLUSH holds state FLUSH.
- Next-PC priority, evaluated every cycle (highest first):
  1. ex_branch_taken: pc<=ex_branch_target; if_flush=1, id_flush=1.
  2. pc_src=100: pc holds; no flush outputs.
  3. Interrupt accept, when all hold: irq_pending, pch=0, state=RUN, pc_src not 101. Action: pc<=XADR_VEC; epc=id_pc_plus4-4; epc_we=1; irq_ack=1; exc_cause=10; if_flush=1, id_flush=1.
  4. pc_src=101: pc<=ILLOP_VEC; epc=id_pc_plus4; epc_we=1; exc_cause=01; if_flush=1, id_flush=1.
  5. pc_src=001: pc<={id_pc_plus4[31:28], id_jump_idx, 2'b00}; if_flush=1.
  6. pc_src=010: pc<={id_jr_data[31] & pch, id_jr_data[30:0]}; if_flush=1. jr may clear the kernel bit but never set it.
  7. Otherwise (000, 011, undefined codes): pc<=pc+4, wrapping mod 2^32 with bit31 preserved, i.e. {pc[31], pc[30:0]+4}.
- Interrupts are never accepted in kernel mode (pch=1) or in FLUSH state, because ID then holds a bubble and epc would be invalid.
- All flush, epc and irq_ack outputs are combinational, valid in the same cycle as their cause. pc updates on the next rising edge.

Optional Feature:
PCSEQ_IRQ_EN
- Defined: interrupt latch, accept logic and XADR path are present as described.
- Undefined: irq is ignored, irq_pending is absent, irq_ack=0, and exc_cause never reads 10. All other behaviour is unchanged.

Decomposition:
- Shared package pc_seq_pkg:
  - pc_src encodings PCSRC_SEQ/JUMP/JR/BRANCH/STALL/UI
  - exc_cause codes
  - FSM state enum
  - default vector constants
- One natural sub-module: pc_next_mux, purely combinational. Implements priority resolution and target formation. The top level holds the pc register, FSM and irq latch.

Test Plan:
- Reset then pc_src=000 for 3 cycles -> pc = 0x80000000, 0x80000004, 0x80000008, 0x8000000C; pch=1.
- pc=user, pc_src=001, id_pc_plus4=0x00400010, id_jump_idx=0x0100008 -> if_flush=1, next pc=0x00400020, then state FLUSH for 1 cycle.
- ex_branch_taken=1, ex_branch_target=0x00000080, simultaneous pc_src=100 -> next pc=0x00000080, if_flush=id_flush=1 (branch beats stall).
- pc_src=101, pch=0, id_pc_plus4=0x00000108 -> epc_we=1, epc=0x00000108, exc_cause=01, next pc=0x80000004.
- In kernel: irq=1 pulse, then jr with id_jr_data=0x00000200 -> pc=0x00000200, no ack in FLUSH cycle. Next RUN cycle with id_pc_plus4=0x00000204 -> irq_ack=1, epc=0x00000200, next pc=0x80000008.
- pch=0, pc_src=010, id_jr_data=0x80001000 -> next pc=0x00001000 (kernel bit not set from user mode).

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings, FSM state and vector defaults for the PC sequencer.
// Includes the sequential-increment helper, which keeps the kernel bit fixed across wrap.
package pc_seq_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_JUMP   = 3'b001;
  localparam logic [2:0] PCSRC_JR     = 3'b010;
  localparam logic [2:0] PCSRC_BRANCH = 3'b011;
  localparam logic [2:0] PCSRC_STALL  = 3'b100;
  localparam logic [2:0] PCSRC_UI     = 3'b101;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ILLOP = 2'b01;
  localparam logic [1:0] EXC_XADR  = 2'b10;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic        if_flush;
    logic        id_flush;
    logic        epc_we;
    logic [31:0] epc;
    logic        irq_ack;
    logic [1:0]  exc_cause;
  } ctl_t;

  // Wraps within the current mode: user code never walks into kernel space.
  function automatic logic [31:0] pc_seq_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority resolver and target formation; purely combinational, zero latency.
// Stall only freezes the PC; a taken EX branch overrides it.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic [2:0]  pc_src,
  input  logic [31:0] pc,
  input  logic [31:0] id_pc_plus4,
  input  logic [25:0] id_jump_idx,
  input  logic [31:0] id_jr_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        irq_pending,
  input  logic        in_run,
  output logic [31:0] pc_next,
  output ctl_t        ctl,
  output logic        redirect,
  output logic        stall
);

  logic irq_take;

  // ID holds a bubble in FLUSH, so there is no valid return address to save.
  assign irq_take = irq_pending & ~pc[31] & in_run & (pc_src != PCSRC_UI);

  always_comb begin
    pc_next       = pc_seq_inc(pc);
    ctl           = '0;
    ctl.exc_cause = EXC_NONE;
    redirect      = 1'b0;
    stall         = 1'b0;

    if (ex_branch_taken) begin
      pc_next      = ex_branch_target;
      ctl.if_flush = 1'b1;
      ctl.id_flush = 1'b1;
      redirect     = 1'b1;
    end else if (pc_src == PCSRC_STALL) begin
      pc_next = pc;
      stall   = 1'b1;
    end else if (irq_take) begin
      pc_next       = XADR_VEC;
      ctl.epc_we    = 1'b1;
      ctl.epc       = id_pc_plus4 - 32'd4;
      ctl.irq_ack   = 1'b1;
      ctl.exc_cause = EXC_XADR;
      ctl.if_flush  = 1'b1;
      ctl.id_flush  = 1'b1;
      redirect      = 1'b1;
    end else begin
      case (pc_src)
        PCSRC_UI: begin
          pc_next       = ILLOP_VEC;
          ctl.epc_we    = 1'b1;
          ctl.epc       = id_pc_plus4;
          ctl.exc_cause = EXC_ILLOP;
          ctl.if_flush  = 1'b1;
          ctl.id_flush  = 1'b1;
          redirect      = 1'b1;
        end
        PCSRC_JUMP: begin
          pc_next      = {id_pc_plus4[31:28], id_jump_idx, 2'b00};
          ctl.if_flush = 1'b1;
          redirect     = 1'b1;
        end
        PCSRC_JR: begin
          // jr can drop to user mode but never escalate into kernel mode.
          pc_next      = {id_jr_data[31] & pc[31], id_jr_data[30:0]};
          ctl.if_flush = 1'b1;
          redirect     = 1'b1;
        end
        PCSRC_SEQ, PCSRC_BRANCH: pc_next = pc_seq_inc(pc);
        default:                 pc_next = pc_seq_inc(pc);
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, RUN/FLUSH FSM and interrupt latch; flush/EPC outputs are same-cycle, PC is registered.
// Interrupt support is built only when PCSEQ_IRQ_EN is defined; stall freezes the PC unless an EX branch is taken.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pc_src,
  input  logic [31:0] id_pc_plus4,
  input  logic [25:0] id_jump_idx,
  input  logic [31:0] id_jr_data,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        irq,
  output logic [31:0] pc,
  output logic        pch,
  output logic        if_flush,
  output logic        id_flush,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic        irq_ack,
  output logic [1:0]  exc_cause
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        irq_pending;
  logic        redirect, stall;
  ctl_t        ctl_raw, ctl_out;

  pc_next_mux #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_next_mux (
    .pc_src           (pc_src),
    .pc               (pc_q),
    .id_pc_plus4      (id_pc_plus4),
    .id_jump_idx      (id_jump_idx),
    .id_jr_data       (id_jr_data),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .irq_pending      (irq_pending),
    .in_run           (state_q == ST_RUN),
    .pc_next          (pc_d),
    .ctl              (ctl_raw),
    .redirect         (redirect),
    .stall            (stall)
  );

`ifdef PCSEQ_IRQ_EN
  logic irq_pending_q, irq_pending_d;

  // A still-asserted level re-arms the latch even in the cycle it is accepted.
  always_comb begin
    irq_pending_d = irq | (irq_pending_q & ~ctl_raw.irq_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) irq_pending_q <= 1'b0;
    else       irq_pending_q <= irq_pending_d;
  end

  assign irq_pending = irq_pending_q;
`else
  logic unused_irq;
  assign unused_irq  = irq;
  assign irq_pending = 1'b0;
`endif

  always_comb begin
    state_d = ST_RUN;
    if (redirect) begin
      state_d = ST_FLUSH;
    end else if (stall && (state_q == ST_FLUSH)) begin
      state_d = ST_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    ctl_out = ctl_raw;
    if (reset) ctl_out = '0;
  end

  assign pc        = pc_q;
  assign pch       = pc_q[31];
  assign if_flush  = ctl_out.if_flush;
  assign id_flush  = ctl_out.id_flush;
  assign epc_we    = ctl_out.epc_we;
  assign epc       = ctl_out.epc;
  assign irq_ack   = ctl_out.irq_ack;
  assign exc_cause = ctl_out.exc_cause;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; interrupt expectations follow PCSEQ_IRQ_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pc_src;
  logic [31:0] id_pc_plus4;
  logic [25:0] id_jump_idx;
  logic [31:0] id_jr_data;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        irq;
  logic [31:0] pc;
  logic        pch;
  logic        if_flush;
  logic        id_flush;
  logic        epc_we;
  logic [31:0] epc;
  logic        irq_ack;
  logic [1:0]  exc_cause;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pc_src           (pc_src),
    .id_pc_plus4      (id_pc_plus4),
    .id_jump_idx      (id_jump_idx),
    .id_jr_data       (id_jr_data),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .irq              (irq),
    .pc               (pc),
    .pch              (pch),
    .if_flush         (if_flush),
    .id_flush         (id_flush),
    .epc_we           (epc_we),
    .epc              (epc),
    .irq_ack          (irq_ack),
    .exc_cause        (exc_cause)
  );

`ifdef PCSEQ_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, JR = 3'b010, BRN = 3'b011,
                         STL = 3'b100, UI = 3'b101, UND = 3'b110;

  typedef struct {
    string       tag;
    logic        ifl;
    logic        idf;
    logic        we;
    logic [31:0] epc;
    logic        ack;
    logic [1:0]  cause;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge, queues its expectation,
  // checks combinational outputs mid-low-phase and the PC just after the edge.
  task automatic step(input string tag, input logic [2:0] src, input logic [31:0] pp4,
                      input logic [25:0] jidx, input logic [31:0] jrd, input logic bt,
                      input logic [31:0] btgt, input logic irqv, input logic rst,
                      input logic ifl, input logic idf, input logic we, input logic [31:0] e_epc,
                      input logic ack, input logic [1:0] cause, input logic [31:0] npc);
    exp_t e;
    reset            = rst;
    pc_src           = src;
    id_pc_plus4      = pp4;
    id_jump_idx      = jidx;
    id_jr_data       = jrd;
    ex_branch_taken  = bt;
    ex_branch_target = btgt;
    irq              = irqv;
    e.tag = tag; e.ifl = ifl; e.idf = idf; e.we = we;
    e.epc = e_epc; e.ack = ack; e.cause = cause; e.npc = npc;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check({e.tag, ".if_flush"},  32'(if_flush),  32'(e.ifl));
    check({e.tag, ".id_flush"},  32'(id_flush),  32'(e.idf));
    check({e.tag, ".epc_we"},    32'(epc_we),    32'(e.we));
    check({e.tag, ".epc"},       epc,            e.epc);
    check({e.tag, ".irq_ack"},   32'(irq_ack),   32'(e.ack));
    check({e.tag, ".exc_cause"}, 32'(exc_cause), 32'(e.cause));
    @(posedge clk);
    #1;
    check({e.tag, ".pc"},  pc,         e.npc);
    check({e.tag, ".pch"}, 32'(pch),   32'(e.npc[31]));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_src = SEQ; id_pc_plus4 = '0; id_jump_idx = '0; id_jr_data = '0;
    ex_branch_taken = 1'b0; ex_branch_target = '0; irq = 1'b0;
    @(negedge clk);

    //    tag      src  pp4           jidx           jrd           bt    btgt          irq   rst   ifl idf we  epc           ack cause npc
    step("rst0",  JMP, 32'h0,        26'h0,         32'h0,        1'b1, 32'h1234,     1'b0, 1'b1, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0000);
    step("rst1",  UI,  32'h10,       26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0000);
    step("seq1",  SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0004);
    step("seq2",  SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0008);
    step("seq3",  SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_000C);
    step("jr_ku", JR,  32'h0,        26'h0,         32'h0040_0000,1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0040_0000);
    step("fl1",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0040_0004);
    step("jump",  JMP, 32'h0040_0010,26'h010_0008,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0040_0020);
    step("stlfl", STL, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0040_0020);
    step("fl2",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0040_0024);
    step("brstl", STL, 32'h0,        26'h0,         32'h0,        1'b1, 32'h0000_0080,1'b0, 1'b0, 1, 1, 0, 32'h0,        0, 2'd0, 32'h0000_0080);
    step("fl3",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0084);
    step("ui",    UI,  32'h0000_0108,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1, 1, 1, 32'h0000_0108,0, 2'd1, 32'h8000_0004);
    step("fl4",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0008);
    step("irq_k", SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_000C);
    step("jr200", JR,  32'h0,        26'h0,         32'h0000_0200,1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0200);
    step("noack", SEQ, 32'h0000_0204,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0204);
    step("ack1",  SEQ, 32'h0000_0204,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, IRQ, IRQ, IRQ, IRQ ? 32'h0000_0200 : 32'h0,
         IRQ, IRQ ? 2'd2 : 2'd0, IRQ ? 32'h8000_0008 : 32'h0000_0208);
    step("br300", SEQ, 32'h0,        26'h0,         32'h0,        1'b1, 32'h0000_0300,1'b0, 1'b0, 1, 1, 0, 32'h0,        0, 2'd0, 32'h0000_0300);
    step("fl5",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0304);
    step("clr",   SEQ, 32'h0000_0308,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0308);
    step("irq_u", SEQ, 32'h0000_030C,26'h0,         32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_030C);
    step("uiirq", UI,  32'h0000_0310,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1, 1, 1, 32'h0000_0310,0, 2'd1, 32'h8000_0004);
    step("jr400", JR,  32'h0,        26'h0,         32'h0000_0400,1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0400);
    step("fl6",   SEQ, 32'h0000_0404,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0404);
    step("stlir", STL, 32'h0000_0408,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0404);
    step("ack2",  SEQ, 32'h0000_0408,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, IRQ, IRQ, IRQ, IRQ ? 32'h0000_0404 : 32'h0,
         IRQ, IRQ ? 2'd2 : 2'd0, IRQ ? 32'h8000_0008 : 32'h0000_0408);
    step("brtop", SEQ, 32'h0,        26'h0,         32'h0,        1'b1, 32'h7FFF_FFFC,1'b0, 1'b0, 1, 1, 0, 32'h0,        0, 2'd0, 32'h7FFF_FFFC);
    step("wrapu", SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0000);
    step("jr_uk", JR,  32'h0,        26'h0,         32'h8000_1000,1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0000_1000);
    step("brktp", SEQ, 32'h0,        26'h0,         32'h0,        1'b1, 32'hFFFF_FFFC,1'b0, 1'b0, 1, 1, 0, 32'h0,        0, 2'd0, 32'hFFFF_FFFC);
    step("wrapk", SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0000);
    step("jmphi", JMP, 32'h9000_0000,26'h3FF_FFFF,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h9FFF_FFFC);
    step("undef", UND, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'hA000_0000);
    step("brid",  BRN, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'hA000_0004);
    step("rstmd", UI,  32'h0000_0020,26'h0,         32'h0,        1'b1, 32'h0000_0055,1'b0, 1'b1, 0, 0, 0, 32'h0,        0, 2'd0, 32'h8000_0000);
    step("jr100", JR,  32'h0,        26'h0,         32'h0000_0100,1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0100);
    step("fl7",   SEQ, 32'h0,        26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0104);
    step("rstcl", SEQ, 32'h0000_0108,26'h0,         32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 0, 32'h0,        0, 2'd0, 32'h0000_0108);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
